// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/mret sequencer between ROB commit, FTQ, CSR file and redirect.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets (mtvec mode 1).
module trap_ctrl #(
    parameter int XLEN      = 64,
    parameter int FTQ_IDX_W = 4,
    parameter int FTQ_OFS_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_trap_req,
    input  logic                 i_is_interrupt,
    input  logic [5:0]           i_cause,
    input  logic [XLEN-1:0]      i_tval,
    input  logic [FTQ_IDX_W-1:0] i_ftq_idx,
    input  logic [FTQ_OFS_W-1:0] i_ftq_ofs,
    input  logic                 i_use_npc,
    input  logic [XLEN-1:0]      i_npc,
    input  logic                 i_mret_req,
    output logic                 o_busy,
    output logic                 o_read_ftq_vld,
    output logic [FTQ_IDX_W-1:0] o_read_ftqIdx,
    input  logic [XLEN-1:0]      i_read_ftqStartAddr,
    input  logic [XLEN-1:0]      i_csr_tvec,
    input  logic [XLEN-1:0]      i_csr_mepc,
    output logic                 o_csr_trap_vld,
    output logic [XLEN-1:0]      o_csr_mepc,
    output logic [XLEN-1:0]      o_csr_mcause,
    output logic [XLEN-1:0]      o_csr_mtval,
    output logic                 o_csr_mret_vld,
    output logic                 o_squash_vld,
    output logic [XLEN-1:0]      o_squash_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDFTQ,
        S_CALC,
        S_FIRE,
        S_MRET
    } state_t;

    state_t                 state;
    logic                   lat_is_int;
    logic [5:0]             lat_cause;
    logic [XLEN-1:0]        lat_tval;
    logic [FTQ_OFS_W-1:0]   lat_ofs;
    logic                   lat_use_npc;
    logic [XLEN-1:0]        lat_npc;

    logic [XLEN-1:0]        tvec_base;
    logic [XLEN-1:0]        trap_target;
    logic [XLEN-1:0]        mepc_calc;

    assign tvec_base = {i_csr_tvec[XLEN-1:2], 2'b00};
    assign mepc_calc = lat_use_npc ? lat_npc
                     : i_read_ftqStartAddr + {{(XLEN-FTQ_OFS_W){1'b0}}, lat_ofs};

    always_comb begin
        trap_target = tvec_base;
`ifdef TRAP_VECTORED_EN
        // Only interrupts are vectored; exceptions always land on the base.
        if (i_csr_tvec[1:0] == 2'b01 && lat_is_int)
            trap_target = tvec_base + ({{(XLEN-6){1'b0}}, lat_cause} << 2);
`endif
    end

`ifndef TRAP_VECTORED_EN
    logic unused_tvec_mode;
    assign unused_tvec_mode = ^i_csr_tvec[1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            lat_is_int     <= 1'b0;
            lat_cause      <= '0;
            lat_tval       <= '0;
            lat_ofs        <= '0;
            lat_use_npc    <= 1'b0;
            lat_npc        <= '0;
            o_busy         <= 1'b0;
            o_read_ftq_vld <= 1'b0;
            o_read_ftqIdx  <= '0;
            o_csr_trap_vld <= 1'b0;
            o_csr_mepc     <= '0;
            o_csr_mcause   <= '0;
            o_csr_mtval    <= '0;
            o_csr_mret_vld <= 1'b0;
            o_squash_vld   <= 1'b0;
            o_squash_pc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Trap has priority; a coincident mret is dropped.
                    if (i_trap_req) begin
                        state          <= S_RDFTQ;
                        lat_is_int     <= i_is_interrupt;
                        lat_cause      <= i_cause;
                        lat_tval       <= i_tval;
                        lat_ofs        <= i_ftq_ofs;
                        lat_use_npc    <= i_use_npc;
                        lat_npc        <= i_npc;
                        o_busy         <= 1'b1;
                        o_read_ftq_vld <= 1'b1;
                        o_read_ftqIdx  <= i_ftq_idx;
                    end else if (i_mret_req) begin
                        state          <= S_MRET;
                        o_busy         <= 1'b1;
                        o_csr_mret_vld <= 1'b1;
                        o_squash_vld   <= 1'b1;
                        o_squash_pc    <= i_csr_mepc;
                    end
                end
                S_RDFTQ: begin
                    state          <= S_CALC;
                    o_read_ftq_vld <= 1'b0;
                    o_read_ftqIdx  <= '0;
                end
                S_CALC: begin
                    state          <= S_FIRE;
                    o_csr_trap_vld <= 1'b1;
                    o_squash_vld   <= 1'b1;
                    o_csr_mepc     <= mepc_calc;
                    o_csr_mcause   <= {lat_is_int, {(XLEN-7){1'b0}}, lat_cause};
                    o_csr_mtval    <= lat_is_int ? '0 : lat_tval;
                    o_squash_pc    <= trap_target;
                end
                S_FIRE, S_MRET: begin
                    state          <= S_IDLE;
                    o_busy         <= 1'b0;
                    o_csr_trap_vld <= 1'b0;
                    o_csr_mret_vld <= 1'b0;
                    o_squash_vld   <= 1'b0;
                    o_csr_mepc     <= '0;
                    o_csr_mcause   <= '0;
                    o_csr_mtval    <= '0;
                    o_squash_pc    <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
